spi_master_fifo: RTL and testbench
==================================

Name: spi_master_fifo

Overview:
- Parametrised SPI master; next generation of the single-byte output-only SPI driver on the CPU memory-mapped I/O bus.
- Adds: configurable word width, TX FIFO, runtime clock divider, all four CPOL/CPHA modes, MISO capture, multiple chip selects and a D/C line.
- Sits behind one write-strobed address decode (push) plus status/read-data decodes in the top-level system, clocked at 62.5 MHz.

Parameters:
- DW, 8, bits per frame (>=2).
- DEPTH, 4, TX FIFO entries (power of 2, >=2).
- NCS, 1, number of chip-select outputs (>=1).
- DIVW, 8, width of half-period divider input.
- SW, 1, width of cs_sel (clog2(NCS), min 1).
- LW, 3, width of level (clog2(DEPTH)+1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  push strobe: {dc_in, cs_sel, din} written to TX FIFO.
- din  in  DW  frame data, MSB first.
- dc_in  in  1  data(1)/command(0) flag for the frame.
- cs_sel  in  SW  chip select index for the frame.
- div  in  DIVW  SCK half-period in clk cycles; 0 treated as 1.
- cpol  in  1  SCK idle level.
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge.
- miso  in  1  serial input.
- sck  out  1  serial clock.
- mosi  out  1  serial output.
- cs_n  out  NCS  active-low chip selects.
- dc  out  1  D/C line, valid while cs_n is low.
- rdata  out  DW  last received word.
- rvalid  out  1  one-cycle pulse when rdata updates.
- busy  out  1  state != IDLE or FIFO non-empty.
- full  out  1  FIFO full.
- level  out  LW  FIFO occupancy.
- ovf  out  1  sticky overflow flag.

Behaviour:
- Reset values: sck=0, mosi=0, cs_n=all 1, dc=0, rdata=0, rvalid=0, ovf=0, FIFO empty, state IDLE.
- Reset mid-frame aborts immediately; FIFO contents are discarded.
- FIFO push:
  - start && !full: push.
  - start && full && no pop this cycle: dropped; ovf<=1 until reset.
  - start && full with pop in the same cycle: push accepted.
  - level is updated on the edge after push/pop.
- Mode latch: div (0 mapped to 1) = H, cpol and cpha are latched on the IDLE->SETUP transition. Mid-frame changes are ignored.
- IDLE: sck=cpol, cs_n all 1. If FIFO non-empty: pop, load shift register, set dc and cs_n[cs_sel]=0 (no CS asserts if cs_sel>=NCS), go SETUP. First cs_n low is 2 edges after the first push into an empty idle block.
- SETUP (H cycles): if cpha=0, mosi=MSB.
- SHIFT (2*DW half-periods of H cycles each; sck toggles at the end of each half-period):
  - cpha=0: sample miso on odd (leading) edges; shift out the next bit on even edges, except the last.
  - cpha=1: drive the next bit on leading edges; sample on trailing edges.
  - Exactly DW samples, MSB first. After 2*DW toggles sck is back at cpol.
- HOLD (H cycles), then at the same edge:
  - cs_n all 1.
  - rdata <= captured word.
  - rvalid=1 for one cycle.
  - go GAP.
- GAP (H cycles, cs_n high, sck=cpol), then IDLE. Back-to-back frames therefore have >=H+1 cycles of cs_n high.
- Frame length, cs_n low: (2*DW+2)*H cycles.
- mosi holds its last value outside SHIFT. dc holds until the next frame.

Test Plan:
- DW=8, div=25, mode 0, miso tied to mosi, push 0xA5, dc_in=1 -> cs_n low 450 cycles, 8 rising sck edges, mosi bits 1,0,1,0,0,1,0,1 stable at rising edges, rdata=0xA5, one rvalid pulse, dc=1.
- Mode 3 (cpol=1, cpha=1), div=2, push 0x3C with miso stuck 1 -> sck idles 1, frame 36 cycles, rdata=0xFF, mosi valid at rising edges.
- div=0 -> behaves as H=1, frame 18 cycles.
- DEPTH=4: six back-to-back pushes 0x01..0x06 from idle -> first popped immediately; pushes 2-5 fill FIFO (full=1, level=4); sixth sets ovf. Frames 0x01..0x05 transmitted in order, each separated by >=H+1 cs_n-high cycles; busy drops after the fifth.
- Assert reset halfway through SHIFT -> cs_n all 1, sck=0, level=0, no rvalid on the next cycle.
- NCS=2: cs_sel=1 -> only cs_n[1] low. cs_sel=0 with cpol toggled mid-frame -> sck level is unaffected until the next frame.

Source files
------------

// File: rtl/spi_master_fifo.sv
// -----------------------------------------------------------------------------
// spi_master_fifo
//   SPI master with a small TX FIFO. Each FIFO entry carries one frame:
//   {dc flag, chip-select index, data word}. Frames are sent MSB first in any
//   of the four CPOL/CPHA modes. The half-period H comes from the div input
//   (0 is treated as 1). H, cpol and cpha are sampled when a frame is popped.
//   The word received on miso is reported on rdata with a one-cycle rvalid.
//
// Ports
//   clk, reset        system clock, asynchronous active-high reset
//   start             push {dc_in, cs_sel, din} into the TX FIFO
//   din, dc_in,cs_sel frame data, D/C flag, chip-select index
//   div               SCK half-period in clk cycles (0 -> 1)
//   cpol, cpha        SPI mode for the next frame
//   miso              serial input
//   sck, mosi         serial clock / serial output
//   cs_n              active-low chip selects
//   dc                D/C line for the current or last frame
//   rdata, rvalid     last received word, update strobe
//   busy, full, level FSM/FIFO status
//   ovf               sticky overflow (push dropped on full FIFO)
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | sck = cpol, cs_n high; pops the FIFO when it holds a frame
// SETUP  | cs_n low for H cycles before the first sck edge
// SHIFT  | 2*DW half-periods of H cycles, sck toggles at each end
// HOLD   | H cycles after the last edge, then release cs_n, post rdata
// GAP    | H cycles of cs_n high before the next frame may start
// -----------------------------------------------------------------------------
module spi_master_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int NCS   = 1,
    parameter int DIVW  = 8,
    parameter int SW    = 1,
    parameter int LW    = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [DW-1:0]   din,
    input  logic            dc_in,
    input  logic [SW-1:0]   cs_sel,
    input  logic [DIVW-1:0] div,
    input  logic            cpol,
    input  logic            cpha,
    input  logic            miso,
    output logic            sck,
    output logic            mosi,
    output logic [NCS-1:0]  cs_n,
    output logic            dc,
    output logic [DW-1:0]   rdata,
    output logic            rvalid,
    output logic            busy,
    output logic            full,
    output logic [LW-1:0]   level,
    output logic            ovf
);

    localparam int EW = DW + SW + 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(2 * DW);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t          state;

    logic [EW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   count;
    logic            push;
    logic            pop;
    logic [EW-1:0]   head;
    logic [DW-1:0]   head_data;
    logic [SW-1:0]   head_cs;
    logic            head_dc;

    logic [DIVW-1:0] h_now;
    logic [DIVW-1:0] h_lat;
    logic            cpha_lat;
    logic [DIVW-1:0] cnt;
    logic [CW-1:0]   edge_left;
    logic [DW-1:0]   tx_sh;
    logic [DW-1:0]   rx_sh;
    logic            sample_edge;

    assign head      = mem[rd_ptr];
    assign head_data = head[DW-1:0];
    assign head_cs   = head[DW+SW-1:DW];
    assign head_dc   = head[EW-1];

    assign full  = (count == LW'(DEPTH));
    assign pop   = (state == S_IDLE) && (count != '0);
    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign push  = start && (!full || pop);
    assign level = count;
    assign busy  = (state != S_IDLE) || (count != '0);

    assign h_now = (div == '0) ? DIVW'(1) : div;

    // edge_left counts down from 2*DW-1, so odd values mark leading edges.
    // cpha=0 samples on leading edges, cpha=1 on trailing edges.
    assign sample_edge = edge_left[0] ^ cpha_lat;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {dc_in, cs_sel, din};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (start && full && !pop) begin
                ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            sck       <= 1'b0;
            mosi      <= 1'b0;
            cs_n      <= '1;
            dc        <= 1'b0;
            rdata     <= '0;
            rvalid    <= 1'b0;
            h_lat     <= DIVW'(1);
            cpha_lat  <= 1'b0;
            cnt       <= '0;
            edge_left <= '0;
            tx_sh     <= '0;
            rx_sh     <= '0;
        end else begin
            rvalid <= 1'b0;
            case (state)
                S_IDLE: begin
                    sck  <= cpol;
                    cs_n <= '1;
                    if (pop) begin
                        h_lat     <= h_now;
                        cpha_lat  <= cpha;
                        cnt       <= h_now - 1'b1;
                        edge_left <= CW'(2 * DW - 1);
                        rx_sh     <= '0;
                        dc        <= head_dc;
                        // An out-of-range index leaves every select deasserted.
                        for (int i = 0; i < NCS; i++) begin
                            cs_n[i] <= (int'(head_cs) != i);
                        end
                        if (!cpha) begin
                            mosi  <= head_data[DW-1];
                            tx_sh <= head_data << 1;
                        end else begin
                            tx_sh <= head_data;
                        end
                        state <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    if (cnt == '0) begin
                        cnt   <= h_lat - 1'b1;
                        state <= S_SHIFT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                S_SHIFT: begin
                    if (cnt == '0) begin
                        cnt <= h_lat - 1'b1;
                        sck <= ~sck;
                        if (sample_edge) begin
                            rx_sh <= {rx_sh[DW-2:0], miso};
                        end else if (edge_left != '0) begin
                            // The final trailing edge of cpha=0 drives nothing.
                            mosi  <= tx_sh[DW-1];
                            tx_sh <= tx_sh << 1;
                        end
                        if (edge_left == '0) begin
                            state <= S_HOLD;
                        end else begin
                            edge_left <= edge_left - 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                S_HOLD: begin
                    if (cnt == '0) begin
                        cs_n   <= '1;
                        rdata  <= rx_sh;
                        rvalid <= 1'b1;
                        cnt    <= h_lat - 1'b1;
                        state  <= S_GAP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                S_GAP: begin
                    if (cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_fifo.sv
// -----------------------------------------------------------------------------
// tb_spi_master_fifo
//   Directed and randomized frames against spi_master_fifo (DW=8, DEPTH=4,
//   NCS=2). A bus-level slave watches cs_n/sck on the falling clk edge,
//   captures mosi on sample edges, serves miso from a slave word and records
//   each frame (length, edges, mosi word, selects, idle levels, cs gap).
// -----------------------------------------------------------------------------
module tb_spi_master_fifo;

    localparam int DW = 8;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] din;
    logic       dc_in;
    logic [0:0] cs_sel;
    logic [7:0] div;
    logic       cpol;
    logic       cpha;
    logic       miso;
    logic       sck;
    logic       mosi;
    logic [1:0] cs_n;
    logic       dc;
    logic [7:0] rdata;
    logic       rvalid;
    logic       busy;
    logic       full;
    logic [2:0] level;
    logic       ovf;

    spi_master_fifo #(
        .DW(8), .DEPTH(4), .NCS(2), .DIVW(8), .SW(1), .LW(3)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .din(din), .dc_in(dc_in),
        .cs_sel(cs_sel), .div(div), .cpol(cpol), .cpha(cpha), .miso(miso),
        .sck(sck), .mosi(mosi), .cs_n(cs_n), .dc(dc), .rdata(rdata),
        .rvalid(rvalid), .busy(busy), .full(full), .level(level), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #8 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         len;
        int         edges;
        int         rising;
        int         gap;
        logic [7:0] mosi_w;
        logic [1:0] cs;
        logic       dc;
        logic       sck0;
        logic       sck_end;
    } frame_t;

    frame_t     frames[$];
    logic [7:0] rx_q[$];

    // slave / monitor state
    int         miso_mode = 0;    // 0: loopback, 1: stuck high, 2: slave word
    logic       mon_cpha = 1'b0;
    logic [7:0] slave_word = 8'h00;
    logic       slave_bit = 1'b0;
    logic [7:0] cur_slave;
    int         bidx;
    int         hi_cnt = 0;
    logic       in_frame = 1'b0;
    logic       prev_sck = 1'b0;
    logic       mon_cs_low;
    frame_t     cur;

    assign miso = (miso_mode == 0) ? mosi : (miso_mode == 1) ? 1'b1 : slave_bit;

    always @(negedge clk) begin
        mon_cs_low = (cs_n != 2'b11);
        if (reset) begin
            in_frame = 1'b0;
            hi_cnt   = 0;
        end else if (!in_frame) begin
            if (mon_cs_low) begin
                in_frame   = 1'b1;
                cur.len    = 1;
                cur.edges  = 0;
                cur.rising = 0;
                cur.gap    = hi_cnt;
                cur.mosi_w = 8'h00;
                cur.cs     = cs_n;
                cur.dc     = dc;
                cur.sck0   = sck;
                cur.sck_end = sck;
                cur_slave  = slave_word;
                if (!mon_cpha) begin
                    slave_bit = cur_slave[DW-1];
                    bidx      = DW - 2;
                end else begin
                    bidx = DW - 1;
                end
            end else begin
                hi_cnt++;
            end
        end else begin
            if (mon_cs_low) begin
                cur.len++;
                if (sck != prev_sck) begin
                    cur.edges++;
                    if (sck) cur.rising++;
                    // odd edge count = leading edge
                    if ((cur.edges % 2 == 1) ^ mon_cpha) begin
                        cur.mosi_w = {cur.mosi_w[6:0], mosi};
                    end else if (bidx >= 0) begin
                        slave_bit = cur_slave[bidx];
                        bidx--;
                    end
                end
            end else begin
                cur.sck_end = sck;
                frames.push_back(cur);
                in_frame = 1'b0;
                hi_cnt   = 1;
            end
        end
        if (rvalid && !reset) rx_q.push_back(rdata);
        prev_sck = sck;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] d, input logic dci, input logic csi);
        @(negedge clk);
        din = d; dc_in = dci; cs_sel = csi; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", busy, 0);
    endtask

    task automatic wait_cs_low(input int max_cyc);
        int n;
        n = 0;
        while (cs_n == 2'b11 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check("cs_low_timeout", cs_n != 2'b11, 1);
    endtask

    task automatic set_mode(input logic [7:0] dv, input logic pol, input logic pha,
                            input int mm, input logic [7:0] sw);
        @(negedge clk);
        div = dv; cpol = pol; cpha = pha; mon_cpha = pha;
        miso_mode = mm; slave_word = sw;
        @(negedge clk);
        frames.delete();
        rx_q.delete();
    endtask

    // One isolated frame; expectations come from the SPI frame rules.
    task automatic run_frame(input string tag, input logic [7:0] d, input logic dci,
                             input logic csi, input logic [7:0] dv, input logic pol,
                             input logic pha, input int mm, input logic [7:0] sw);
        int         h;
        logic [7:0] exp_rx;
        frame_t     f;
        h      = (dv == 8'd0) ? 1 : int'(dv);
        exp_rx = (mm == 0) ? d : (mm == 1) ? 8'hFF : sw;
        set_mode(dv, pol, pha, mm, sw);
        push_word(d, dci, csi);
        wait_idle(40 * h + 100);
        repeat (2) @(negedge clk);
        f = '{default: 0};
        if (frames.size() > 0) f = frames[0];
        check({tag, "_nframes"}, frames.size(), 1);
        check({tag, "_len"}, f.len, (2 * DW + 2) * h);
        check({tag, "_edges"}, f.edges, 2 * DW);
        check({tag, "_rising"}, f.rising, DW);
        check({tag, "_mosi"}, f.mosi_w, d);
        check({tag, "_cs"}, f.cs, csi ? 2'b01 : 2'b10);
        check({tag, "_dc"}, f.dc, dci);
        check({tag, "_sck_idle"}, f.sck0, pol);
        check({tag, "_sck_end"}, f.sck_end, pol);
        check({tag, "_nrvalid"}, rx_q.size(), 1);
        check({tag, "_rdata"}, rdata, exp_rx);
        check({tag, "_dc_hold"}, dc, dci);
    endtask

    initial begin
        logic [7:0] rd;
        logic [7:0] rdv;
        logic       rpol;
        logic       rpha;
        logic       rdc;
        logic       rcs;
        int         rmm;
        logic [7:0] rsw;
        int         exp_lvl;

        reset = 1'b1; start = 1'b0; din = 8'h00; dc_in = 1'b0; cs_sel = 1'b0;
        div = 8'd1; cpol = 1'b0; cpha = 1'b0;
        #1;
        check("rst_sck", sck, 0);
        check("rst_mosi", mosi, 0);
        check("rst_cs_n", cs_n, 2'b11);
        check("rst_dc", dc, 0);
        check("rst_rdata", rdata, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_ovf", ovf, 0);
        check("rst_level", level, 0);
        check("rst_busy", busy, 0);
        check("rst_full", full, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // mode 0, H=25, loopback
        run_frame("m0_a5", 8'hA5, 1'b1, 1'b0, 8'd25, 1'b0, 1'b0, 0, 8'h00);
        // mode 3, H=2, miso stuck high
        run_frame("m3_3c", 8'h3C, 1'b0, 1'b0, 8'd2, 1'b1, 1'b1, 1, 8'h00);
        // div=0 behaves as H=1
        run_frame("div0", 8'h96, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 2, 8'h6B);
        // second chip select
        run_frame("cs1", 8'hC3, 1'b0, 1'b1, 8'd3, 1'b1, 1'b0, 2, 8'h81);

        // cpol changed mid-frame must not affect this frame
        set_mode(8'd3, 1'b0, 1'b0, 2, 8'h24);
        push_word(8'h5A, 1'b1, 1'b0);
        wait_cs_low(50);
        repeat (10) @(negedge clk);
        cpol = 1'b1;
        wait_idle(200);
        repeat (2) @(negedge clk);
        check("cpolmid_nframes", frames.size(), 1);
        if (frames.size() > 0) begin
            check("cpolmid_sck0", frames[0].sck0, 0);
            check("cpolmid_sck_end", frames[0].sck_end, 0);
            check("cpolmid_edges", frames[0].edges, 2 * DW);
            check("cpolmid_mosi", frames[0].mosi_w, 8'h5A);
        end
        check("cpolmid_rdata", rdata, 8'h24);
        run_frame("cpol_next", 8'h0F, 1'b1, 1'b0, 8'd3, 1'b1, 1'b0, 2, 8'hF0);

        // randomized frames
        for (int k = 0; k < 8; k++) begin
            rd   = 8'($urandom);
            rsw  = 8'($urandom);
            rdv  = 8'($urandom_range(0, 4));
            rpol = 1'($urandom);
            rpha = 1'($urandom);
            rdc  = 1'($urandom);
            rcs  = 1'($urandom);
            rmm  = int'($urandom_range(0, 2));
            run_frame($sformatf("rnd%0d", k), rd, rdc, rcs, rdv, rpol, rpha, rmm, rsw);
        end

        // burst of six pushes into a 4-deep FIFO, H=1, loopback
        set_mode(8'd1, 1'b0, 1'b0, 0, 8'h00);
        for (int i = 0; i < 6; i++) begin
            din = 8'(i + 1); dc_in = 1'b0; cs_sel = 1'b0; start = 1'b1;
            @(negedge clk);
            // the first entry leaves at the second edge; capacity is 4
            exp_lvl = (i >= 1) ? i : i + 1;
            if (exp_lvl > 4) exp_lvl = 4;
            check($sformatf("burst_level%0d", i), level, exp_lvl);
            check($sformatf("burst_full%0d", i), full, exp_lvl == 4);
            check($sformatf("burst_ovf%0d", i), ovf, i == 5);
        end
        start = 1'b0;
        wait_idle(400);
        repeat (2) @(negedge clk);
        check("burst_nframes", frames.size(), 5);
        check("burst_nrvalid", rx_q.size(), 5);
        for (int k = 0; k < frames.size(); k++) begin
            check($sformatf("burst_mosi%0d", k), frames[k].mosi_w, k + 1);
            if (k > 0) check($sformatf("burst_gap%0d", k), frames[k].gap >= 2, 1);
        end
        for (int k = 0; k < rx_q.size(); k++) begin
            check($sformatf("burst_rx%0d", k), rx_q[k], k + 1);
        end
        check("burst_busy", busy, 0);
        check("burst_ovf_sticky", ovf, 1);
        check("burst_level_end", level, 0);

        // reset halfway through SHIFT with FIFO entries pending
        set_mode(8'd4, 1'b0, 1'b0, 0, 8'h00);
        push_word(8'h77, 1'b1, 1'b0);
        push_word(8'h11, 1'b1, 1'b0);
        push_word(8'h22, 1'b1, 1'b0);
        wait_cs_low(50);
        check("rstmid_level_pre", level, 2);
        repeat (4 + 8 * 4 - 5) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("rstmid_cs_n", cs_n, 2'b11);
        check("rstmid_sck", sck, 0);
        check("rstmid_level", level, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_ovf", ovf, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rstmid_rvalid", rvalid, 0);
        repeat (20) @(negedge clk);
        check("rstmid_nrvalid", rx_q.size(), 0);
        check("rstmid_nframes", frames.size(), 0);
        check("rstmid_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
